// File: rtl/pipe_mux_nto1_if.sv
// Handshake/data bundle for pipe_mux_nto1: packed channel inputs, select/mode/control,
// and the registered selection outputs.
interface pipe_mux_nto1_if #(
  parameter int SIZE  = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
);
  logic [NUM*SIZE-1:0] data_i;
  logic [SEL_W-1:0]    select_i;
  logic                mode_i;
  logic                valid_i;
  logic                stall_i;
  logic                flush_i;
  logic [SIZE-1:0]     data_o;
  logic                valid_o;
  logic                sel_err_o;
  logic [SEL_W-1:0]    rr_ptr_o;

  modport slave (
    input  data_i, select_i, mode_i, valid_i, stall_i, flush_i,
    output data_o, valid_o, sel_err_o, rr_ptr_o
  );
  modport master (
    output data_i, select_i, mode_i, valid_i, stall_i, flush_i,
    input  data_o, valid_o, sel_err_o, rr_ptr_o
  );
endinterface

// File: rtl/pipe_mux_nto1.sv
// N-to-1 selector fused with its pipeline register; stall/flush control.
// Optional round-robin auto-select is compiled in with PIPE_MUX_RR_EN.
module pipe_mux_nto1_lane #(
  parameter int SIZE  = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [SIZE-1:0]  din,
  output logic [SIZE-1:0]  dout
);
  localparam logic [SEL_W-1:0] IDX_W = SEL_W'(IDX);
  assign dout = (sel == IDX_W) ? din : '0;
endmodule

module pipe_mux_nto1 #(
  parameter int SIZE  = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_mux_nto1_if.slave    bus
);
  localparam logic [SEL_W:0]   NUM_X = (SEL_W+1)'(NUM);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM-1);

  logic [NUM-1:0][SIZE-1:0] chan, lane_out;
  logic [SIZE-1:0]          mux_d, data_q;
  logic [SEL_W-1:0]         eff_idx;
  logic                     in_range, vld_q, err_q;
  logic                     load;

  assign chan = bus.data_i;
  assign load = !bus.flush_i && !bus.stall_i;

`ifdef PIPE_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr;

  assign eff_idx = bus.mode_i ? rr_ptr : bus.select_i;

  // Pointer only moves on accepted valid data in auto mode; it is never >= NUM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      rr_ptr <= '0;
    else if (load && bus.valid_i && bus.mode_i)
      rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + SEL_W'(1);
  end

  assign bus.rr_ptr_o = rr_ptr;
`else
  logic unused_mode;
  assign unused_mode  = bus.mode_i;
  assign eff_idx      = bus.select_i;
  assign bus.rr_ptr_o = '0;
`endif

  assign in_range = ({1'b0, eff_idx} < NUM_X);

  // One-hot gated lanes OR-reduced; out-of-range index leaves every lane gated off
  for (genvar k = 0; k < NUM; k++) begin : g_lane
    pipe_mux_nto1_lane #(.SIZE(SIZE), .SEL_W(SEL_W), .IDX(k)) u_lane (
      .sel  (eff_idx),
      .din  (chan[k]),
      .dout (lane_out[k])
    );
  end

  always_comb begin
    mux_d = '0;
    for (int j = 0; j < NUM; j++) mux_d = mux_d | lane_out[j];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.flush_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.stall_i) begin
      err_q  <= 1'b0;
    end else if (in_range) begin
      data_q <= mux_d;
      vld_q  <= bus.valid_i;
      err_q  <= 1'b0;
    end else begin
      data_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b1;
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = vld_q;
  assign bus.sel_err_o = err_q;
endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Bench for pipe_mux_nto1: NUM=4 and NUM=3 instances driven side by side,
// vector table, round-robin sequence (when enabled), random run vs reference model.
module tb_pipe_mux_nto1;
`ifdef PIPE_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ch [4];
  logic [1:0]  sel;
  logic        mode, vld, stall, flush;

  always #5 clk = ~clk;

  pipe_mux_nto1_if #(.SIZE(32), .NUM(4), .SEL_W(2)) b4 ();
  pipe_mux_nto1_if #(.SIZE(32), .NUM(3), .SEL_W(2)) b3 ();

  assign b4.data_i   = {ch[3], ch[2], ch[1], ch[0]};
  assign b3.data_i   = {ch[2], ch[1], ch[0]};
  assign b4.select_i = sel;   assign b3.select_i = sel;
  assign b4.mode_i   = mode;  assign b3.mode_i   = mode;
  assign b4.valid_i  = vld;   assign b3.valid_i  = vld;
  assign b4.stall_i  = stall; assign b3.stall_i  = stall;
  assign b4.flush_i  = flush; assign b3.flush_i  = flush;

  pipe_mux_nto1 #(.SIZE(32), .NUM(4), .SEL_W(2)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4));
  pipe_mux_nto1 #(.SIZE(32), .NUM(3), .SEL_W(2)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

  typedef struct {
    logic [31:0] d;
    bit          v;
    bit          e;
    int          ptr;
  } mdl_t;

  typedef struct {
    logic [1:0]  sel;
    bit          v, st, fl;
    logic [31:0] d4; bit v4, e4;
    logic [31:0] d3; bit v3, e3;
  } vec_t;

  mdl_t m4, m3;
  int   n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: outputs after one edge, straight from the selection rules
  function automatic mdl_t mstep(input mdl_t m, input int num, input logic [31:0] c [4]);
    mdl_t r = m;
    int   idx;
    if (flush) begin
      r.d = '0; r.v = 1'b0; r.e = 1'b0;
    end else if (stall) begin
      r.e = 1'b0;
    end else begin
      idx = (RR && mode) ? m.ptr : int'(sel);
      if (idx < num) begin
        r.d = c[idx]; r.v = vld; r.e = 1'b0;
        if (RR && mode && vld) r.ptr = (m.ptr + 1) % num;
      end else begin
        r.d = '0; r.v = 1'b0; r.e = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.d = '0; r.v = 1'b0; r.e = 1'b0; r.ptr = 0;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    m4 = mstep(m4, 4, ch);
    m3 = mstep(m3, 3, ch);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "4.data"},  b4.data_o,            m4.d);
    chk({tag, "4.valid"}, 32'(b4.valid_o),      32'(m4.v));
    chk({tag, "4.err"},   32'(b4.sel_err_o),    32'(m4.e));
    chk({tag, "4.ptr"},   32'(b4.rr_ptr_o),     32'(m4.ptr));
    chk({tag, "3.data"},  b3.data_o,            m3.d);
    chk({tag, "3.valid"}, 32'(b3.valid_o),      32'(m3.v));
    chk({tag, "3.err"},   32'(b3.sel_err_o),    32'(m3.e));
    chk({tag, "3.ptr"},   32'(b3.rr_ptr_o),     32'(m3.ptr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "4.data"},  b4.data_o,         32'h0);
    chk({tag, "4.valid"}, 32'(b4.valid_o),   32'h0);
    chk({tag, "4.err"},   32'(b4.sel_err_o), 32'h0);
    chk({tag, "4.ptr"},   32'(b4.rr_ptr_o),  32'h0);
    chk({tag, "3.data"},  b3.data_o,         32'h0);
    chk({tag, "3.valid"}, 32'(b3.valid_o),   32'h0);
    chk({tag, "3.ptr"},   32'(b3.rr_ptr_o),  32'h0);
  endtask

  // Called just after an edge; pulses reset between edges
  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m4 = mreset();
    m3 = mreset();
  endtask

  vec_t tab [12];

  initial begin
    tab[0]  = '{2'd2, 1, 0, 0, 32'h33333333, 1, 0, 32'h33333333, 1, 0};
    tab[1]  = '{2'd1, 1, 0, 0, 32'h22222222, 1, 0, 32'h22222222, 1, 0};
    tab[2]  = '{2'd3, 1, 1, 0, 32'h22222222, 1, 0, 32'h22222222, 1, 0};
    tab[3]  = '{2'd3, 1, 1, 0, 32'h22222222, 1, 0, 32'h22222222, 1, 0};
    tab[4]  = '{2'd3, 1, 1, 0, 32'h22222222, 1, 0, 32'h22222222, 1, 0};
    tab[5]  = '{2'd3, 1, 0, 0, 32'h44444444, 1, 0, 32'h00000000, 0, 1};
    tab[6]  = '{2'd3, 1, 1, 1, 32'h00000000, 0, 0, 32'h00000000, 0, 0};
    tab[7]  = '{2'd0, 1, 0, 0, 32'h11111111, 1, 0, 32'h11111111, 1, 0};
    tab[8]  = '{2'd3, 1, 0, 0, 32'h44444444, 1, 0, 32'h00000000, 0, 1};
    tab[9]  = '{2'd3, 1, 0, 0, 32'h44444444, 1, 0, 32'h00000000, 0, 1};
    tab[10] = '{2'd0, 1, 0, 0, 32'h11111111, 1, 0, 32'h11111111, 1, 0};
    tab[11] = '{2'd1, 0, 0, 0, 32'h22222222, 0, 0, 32'h22222222, 0, 0};

    ch[0] = 32'h11111111; ch[1] = 32'h22222222;
    ch[2] = 32'h33333333; ch[3] = 32'h44444444;
    sel = '0; mode = 1'b0; vld = 1'b0; stall = 1'b0; flush = 1'b0;
    rst = 1'b1;
    m4 = mreset(); m3 = mreset();
    #2;
    chk_zero("reset.");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      sel = tab[i].sel; vld = tab[i].v; stall = tab[i].st; flush = tab[i].fl;
      cyc();
      chk($sformatf("vec%0d.d4", i), b4.data_o,            tab[i].d4);
      chk($sformatf("vec%0d.v4", i), 32'(b4.valid_o),      32'(tab[i].v4));
      chk($sformatf("vec%0d.e4", i), 32'(b4.sel_err_o),    32'(tab[i].e4));
      chk($sformatf("vec%0d.d3", i), b3.data_o,            tab[i].d3);
      chk($sformatf("vec%0d.v3", i), 32'(b3.valid_o),      32'(tab[i].v3));
      chk($sformatf("vec%0d.e3", i), 32'(b3.sel_err_o),    32'(tab[i].e3));
      cmp_model($sformatf("vec%0d.m", i));
    end

`ifdef PIPE_MUX_RR_EN
    begin
      bit          vpat [6] = '{1, 1, 0, 1, 1, 1};
      int          ppat [6] = '{1, 2, 2, 3, 0, 1};
      logic [31:0] dpat [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                32'h33333333, 32'h44444444, 32'h11111111};
      rst_pulse();
      stall = 1'b0; flush = 1'b0; mode = 1'b1; sel = 2'd3;
      chk("rr.ptr0", 32'(b4.rr_ptr_o), 32'd0);
      for (int i = 0; i < 6; i++) begin
        vld = vpat[i];
        cyc();
        chk($sformatf("rr%0d.ptr", i),  32'(b4.rr_ptr_o), 32'(ppat[i]));
        chk($sformatf("rr%0d.data", i), b4.data_o,        dpat[i]);
        chk($sformatf("rr%0d.vld", i),  32'(b4.valid_o),  32'(vpat[i]));
        cmp_model($sformatf("rr%0d.m", i));
      end
      mode = 1'b0;
    end
`endif

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) ch[c] = $urandom;
      sel   = 2'($urandom_range(0, 3));
      mode  = 1'($urandom_range(0, 1));
      vld   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cyc();
      cmp_model($sformatf("rnd%0d.", i));

      if (i == 200) begin
        // Make sure outputs are live, then hit reset between edges
        sel = 2'd1; mode = 1'b0; vld = 1'b1; stall = 1'b0; flush = 1'b0;
        cyc();
        cmp_model("prerst.");
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst.");
        #2;
        rst = 1'b0;
        m4 = mreset(); m3 = mreset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
